lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Generates raster timing for the 480x272 parallel-RGB LCD panel.
- Drives the pixel-position and enable signals consumed by the `display` pixel renderer: `hcount_reg`, `Vcount_reg`, `flagh`, `flagv`, `rgb_en`.
- Drives the panel's `hsync_n`, `vsync_n`, `de` and `disp_on` pins.
- Sequences panel power-up and power-down in whole frames so the panel never sees a partial frame with DISP asserted.

Parameters:
- H_ACTIVE, 480, visible pixels per line
- H_PULSE, 41, hsync low width (clocks)
- H_BP, 2, back porch after hsync (clocks)
- H_FP, 2, front porch after active (clocks)
- V_ACTIVE, 272, visible lines per frame
- V_PULSE, 10, vsync low width (lines)
- V_BP, 2, vertical back porch (lines)
- V_FP, 2, vertical front porch (lines)
- PWR_FRAMES, 4, blank frames emitted before data is enabled / after data is disabled
- Derived values: H_TOTAL = 525, V_TOTAL = 286, H_START = H_PULSE+H_BP = 43, V_START = V_PULSE+V_BP = 12.

Ports:
- clk_lcd  in  1  pixel clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- lcd_on  in  1  level request: panel on (1) / off (0)
- hcount_reg  out  10  active-area x, 0..479
- Vcount_reg  out  9  active-area y, 0..271
- flagh  out  1  horizontal active window
- flagv  out  1  vertical active window
- rgb_en  out  1  renderer output-register enable
- de  out  1  panel data enable
- hsync_n  out  1  panel hsync, active low
- vsync_n  out  1  panel vsync, active low
- disp_on  out  1  panel DISP pin
- frame_start  out  1  one-cycle pulse at the start of each frame
- pwr_state  out  2  current FSM state, for debug

Behaviour:
- Reset (`rst_n`=0 at a clk_lcd edge):
  - `h_cnt`, `v_cnt`, `frm_cnt` cleared to 0; FSM to OFF.
  - `hcount_reg` = 0, `Vcount_reg` = 0; `flagh`, `flagv`, `rgb_en`, `de`, `disp_on`, `frame_start` = 0.
  - `hsync_n` = 1, `vsync_n` = 1.
  - Reset mid-frame aborts the frame immediately; no completion is required.
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments when `h_cnt` wraps and runs 0..V_TOTAL-1, then wraps.
  - Counters run in every FSM state, including OFF.
- All outputs are registered and derived from the current counter values; counter-to-output latency is 1 clock.
- Sync pulses:
  - `hsync_n` = 0 iff `h_cnt` < H_PULSE.
  - `vsync_n` = 0 iff `v_cnt` < V_PULSE, for all `h_cnt` in those lines.
- Active windows:
  - `flagh` = 1 iff H_START ≤ `h_cnt` < H_START+H_ACTIVE.
  - `flagv` = 1 iff V_START ≤ `v_cnt` < V_START+V_ACTIVE.
- Position outputs:
  - `hcount_reg` = `h_cnt` − H_START while `flagh` condition holds, else 0.
  - `Vcount_reg` = `v_cnt` − V_START while `flagv` condition holds, else 0.
  - Subtraction is unsigned and never wraps, because it is gated by the window.
- Data-enable pipeline (`rgb_en`, `de`):
  - Let `act` = `flagh` & `flagv` & (FSM==RUN).
  - `rgb_en` = `act` delayed 1 clock; this matches the renderer's first register stage.
  - `de` = `act` delayed 2 clocks; this aligns with the renderer's `data_*` outputs.
  - Both pipelines are cleared by reset.
- `frame_start` = 1 for exactly one clock when `h_cnt`==0 and `v_cnt`==0. It pulses every frame in every state.
- FSM (`pwr_state` encoding: OFF=0, WAKE=1, RUN=2, SLEEP=3):
  - OFF:
    - `disp_on` = 0; `act` forced 0.
    - Goes to WAKE on the first `frame_start` with `lcd_on`=1.
  - WAKE:
    - `disp_on` = 1; `act` forced 0.
    - `frm_cnt` increments on each `frame_start`.
    - When `frm_cnt` reaches PWR_FRAMES, go to RUN and clear `frm_cnt`.
    - If `lcd_on` drops, go to OFF at the next `frame_start`.
  - RUN:
    - `disp_on` = 1; data enabled.
    - If `lcd_on`=0 at a `frame_start`, go to SLEEP. The transition therefore happens only at a frame boundary, and the current frame completes with data.
  - SLEEP:
    - `disp_on` = 1; `act` forced 0.
    - Counts PWR_FRAMES frames, then goes to OFF and clears `frm_cnt`.
    - `lcd_on` reasserting in SLEEP is ignored until OFF is reached.
- `lcd_on` is sampled only on `frame_start` cycles; toggles between frame starts have no effect.
- `frm_cnt` is 3 bits wide; PWR_FRAMES must be ≤ 7.

Test Plan:
- Hold `rst_n`=0 for 3 clocks, then release:
  - All outputs at their reset values during reset.
  - First `frame_start` pulse 1 clock after release.
  - `hsync_n` low for exactly 41 clocks per 525-clock line.
  - `vsync_n` low for 10×525 = 5250 clocks per 286-line frame.
- Steady RUN, count over one frame:
  - `flagh`&`flagv` high for exactly 480×272 = 130560 clocks.
  - `hcount_reg` steps 0..479 on every active line; `Vcount_reg` steps 0..271.
  - First active pixel occurs at `h_cnt`=43, `v_cnt`=12 (+1 clock output latency).
- Pipeline alignment:
  - `rgb_en` rises exactly 1 clock after `flagh`&`flagv`.
  - `de` rises exactly 2 clocks after `flagh`&`flagv`.
  - `de` high count per line is 480.
- Power-up:
  - Raise `lcd_on` mid-frame in OFF → state OFF until the next `frame_start`.
  - `disp_on` rises at that `frame_start`.
  - Exactly 4 frames follow with `rgb_en`=0, then RUN with `rgb_en` active.
- Power-down:
  - Drop `lcd_on` mid-frame in RUN → the current frame completes with `de` active.
  - SLEEP follows for 4 frames with `de`=0, then `disp_on` falls at a `frame_start`.
  - A `lcd_on` pulse during SLEEP is ignored.
- Reset mid-line in RUN (`h_cnt`≈300, `v_cnt`≈100):
  - Next clock: counters at 0, `de`=0, `disp_on`=0, state OFF.
  - Sync timing restarts cleanly.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for a parallel-RGB LCD panel.
// Free-running h/v counters feed registered sync, window and position outputs.
// A four-state power FSM changes state only on frame boundaries, so the panel
// never sees a partial frame while DISP is asserted.
// Handshake: there is none. lcd_on is a level request that is looked at only
// on frame-start cycles, and every output is a registered level or pulse.
module lcd_timing_gen #(
    parameter int H_ACTIVE   = 480,
    parameter int H_PULSE    = 41,
    parameter int H_BP       = 2,
    parameter int H_FP       = 2,
    parameter int V_ACTIVE   = 272,
    parameter int V_PULSE    = 10,
    parameter int V_BP       = 2,
    parameter int V_FP       = 2,
    parameter int PWR_FRAMES = 4
) (
    input  logic       clk_lcd,
    input  logic       rst_n,
    input  logic       lcd_on,
    output logic [9:0] hcount_reg,
    output logic [8:0] Vcount_reg,
    output logic       flagh,
    output logic       flagv,
    output logic       rgb_en,
    output logic       de,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       disp_on,
    output logic       frame_start,
    output logic [1:0] pwr_state
);

    localparam int H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SYNC  = 10'(H_PULSE);
    localparam logic [9:0] H_START = 10'(H_PULSE + H_BP);
    localparam logic [9:0] H_END   = 10'(H_PULSE + H_BP + H_ACTIVE);
    localparam logic [8:0] V_LAST  = 9'(V_TOTAL - 1);
    localparam logic [8:0] V_SYNC  = 9'(V_PULSE);
    localparam logic [8:0] V_START = 9'(V_PULSE + V_BP);
    localparam logic [8:0] V_END   = 9'(V_PULSE + V_BP + V_ACTIVE);
    localparam logic [2:0] PWR_LAST = 3'(PWR_FRAMES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        RUN   = 2'd2,
        SLEEP = 2'd3
    } pwr_t;

    logic [9:0] h_cnt;
    logic [8:0] v_cnt;
    logic [2:0] frm_cnt, frm_nxt;
    pwr_t       state, state_nxt;
    logic       fs_cond, h_win, v_win, act, de_d1;

    assign fs_cond   = (h_cnt == 10'd0) && (v_cnt == 9'd0);
    assign h_win     = (h_cnt >= H_START) && (h_cnt < H_END);
    assign v_win     = (v_cnt >= V_START) && (v_cnt < V_END);
    // Data is gated by the registered windows, so rgb_en trails flagh&flagv by one clock.
    assign act       = flagh && flagv && (state == RUN);
    assign pwr_state = state;

    // Free-running raster counters; they keep running in every power state.
    always_ff @(posedge clk_lcd) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 9'd0 : v_cnt + 9'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Registered timing outputs, one clock behind the counters.
    always_ff @(posedge clk_lcd) begin
        if (!rst_n) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            flagh       <= 1'b0;
            flagv       <= 1'b0;
            hcount_reg  <= '0;
            Vcount_reg  <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync_n     <= !(h_cnt < H_SYNC);
            vsync_n     <= !(v_cnt < V_SYNC);
            flagh       <= h_win;
            flagv       <= v_win;
            // Window gating guarantees the subtraction never underflows.
            hcount_reg  <= h_win ? h_cnt - H_START : 10'd0;
            Vcount_reg  <= v_win ? v_cnt - V_START : 9'd0;
            frame_start <= fs_cond;
        end
    end

    // Enable pipeline: rgb_en matches the renderer's first stage, de its data outputs.
    always_ff @(posedge clk_lcd) begin
        if (!rst_n) begin
            rgb_en <= 1'b0;
            de_d1  <= 1'b0;
            de     <= 1'b0;
        end else begin
            rgb_en <= act;
            de_d1  <= act;
            de     <= de_d1;
        end
    end

    // Power FSM state, frame counter and DISP pin.
    always_ff @(posedge clk_lcd) begin
        if (!rst_n) begin
            state   <= OFF;
            frm_cnt <= '0;
            disp_on <= 1'b0;
        end else begin
            state   <= state_nxt;
            frm_cnt <= frm_nxt;
            // Tracking the next state makes DISP change on the same edge as frame_start.
            disp_on <= (state_nxt != OFF);
        end
    end

    // Next-state logic; lcd_on only matters on frame-start cycles.
    always_comb begin
        state_nxt = state;
        frm_nxt   = frm_cnt;
        case (state)
            OFF: begin
                if (fs_cond && lcd_on) begin
                    state_nxt = WAKE;
                    frm_nxt   = '0;
                end
            end
            WAKE: begin
                if (fs_cond) begin
                    if (!lcd_on) begin
                        state_nxt = OFF;
                        frm_nxt   = '0;
                    end else if (frm_cnt == PWR_LAST) begin
                        state_nxt = RUN;
                        frm_nxt   = '0;
                    end else begin
                        frm_nxt = frm_cnt + 3'd1;
                    end
                end
            end
            RUN: begin
                if (fs_cond && !lcd_on) begin
                    state_nxt = SLEEP;
                    frm_nxt   = '0;
                end
            end
            SLEEP: begin
                // A returning lcd_on is ignored here; it is honoured once OFF is reached.
                if (fs_cond) begin
                    if (frm_cnt == PWR_LAST) begin
                        state_nxt = OFF;
                        frm_nxt   = '0;
                    end else begin
                        frm_nxt = frm_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = OFF;
                frm_nxt   = '0;
            end
        endcase
    end

endmodule
